ps2_scancode_ctrl: RTL and testbench

//  Sequencer between the PS/2 frame receiver and keyboard consumers (CPU GPIO/IRQ logic).

---
 rtl/ps2_scancode_ctrl.sv | 162 ++++++++++++++++
 tb/tb_ps2_scancode_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/ps2_scancode_ctrl.sv
// ps2_scancode_ctrl: folds PS/2 Set-2 E0/F0 prefixes into key events buffered in a FWFT FIFO; optional typematic filter via PS2_REPEAT_FILTER_EN
module ps2_scancode_ctrl #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 65500,
    parameter int TO_W           = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic       rx_err,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [7:0] evt_code,
    output logic       evt_ext,
    output logic       evt_brk,
    output logic       err_pulse,
    output logic       to_pulse,
    output logic       overflow,
    input  logic       ovf_clr
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, EXT, BRK} state_t;

    state_t          state, state_d;
    logic            ext_q, ext_d, brk_q, brk_d;
    logic            err_d, to_d, push_req, push, pop, drop, wr, full, bad, timeout;
    logic [TO_W-1:0] to_cnt;
    logic [9:0]      ev;
    logic [9:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     count;

    assign bad     = rx_err || rx_data == 8'h00 || rx_data == 8'hFF;
    assign timeout = state != IDLE && !rx_valid && to_cnt == TO_LAST;
    assign ev      = {ext_q, brk_q, rx_data};

    // prefix parser: decide next state, flags, push and pulse requests
    always_comb begin
        state_d  = state;
        ext_d    = ext_q;
        brk_d    = brk_q;
        push_req = 1'b0;
        err_d    = 1'b0;
        to_d     = 1'b0;
        if (rx_valid && bad) begin
            err_d   = 1'b1;
            ext_d   = 1'b0;
            brk_d   = 1'b0;
            state_d = IDLE;
        end else if (rx_valid) begin
            case (state)
                IDLE: begin
                    if (rx_data == 8'hE0) begin
                        state_d = EXT;
                        ext_d   = 1'b1;
                    end else if (rx_data == 8'hF0) begin
                        state_d = BRK;
                        brk_d   = 1'b1;
                    end else begin
                        push_req = 1'b1;
                    end
                end
                EXT: begin
                    if (rx_data == 8'hF0) begin
                        state_d = BRK;
                        brk_d   = 1'b1;
                    end else if (rx_data != 8'hE0) begin
                        push_req = 1'b1;
                        state_d  = IDLE;
                        ext_d    = 1'b0;
                    end
                end
                BRK: begin
                    err_d    = rx_data == 8'hE0 || rx_data == 8'hF0;
                    push_req = !err_d;
                    state_d  = IDLE;
                    ext_d    = 1'b0;
                    brk_d    = 1'b0;
                end
                default: state_d = IDLE;
            endcase
        end else if (timeout) begin
            to_d    = 1'b1;
            state_d = IDLE;
            ext_d   = 1'b0;
            brk_d   = 1'b0;
        end
    end

    // parser state, flags, prefix age and status pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ext_q     <= 1'b0;
            brk_q     <= 1'b0;
            to_cnt    <= '0;
            err_pulse <= 1'b0;
            to_pulse  <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state     <= state_d;
            ext_q     <= ext_d;
            brk_q     <= brk_d;
            to_cnt    <= (rx_valid || state == IDLE) ? '0 : to_cnt + TO_W'(1);
            err_pulse <= err_d;
            to_pulse  <= to_d;
            overflow  <= ovf_clr ? 1'b0 : overflow | drop;
        end
    end

`ifdef PS2_REPEAT_FILTER_EN
    logic [8:0] last_key;
    logic       last_v, hit;

    assign hit  = last_v && last_key == {ext_q, rx_data};
    assign push = push_req && !(hit && !brk_q);

    // remember the last make so held-key repeats are swallowed until its break
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_v   <= 1'b0;
            last_key <= '0;
        end else if (push_req && !brk_q) begin
            last_v   <= 1'b1;
            last_key <= {ext_q, rx_data};
        end else if (push_req && hit) begin
            last_v <= 1'b0;
        end
    end
`else
    assign push = push_req;
`endif

    assign evt_valid = count != '0;
    assign full      = count == FULL_CNT;
    assign pop       = evt_ready && evt_valid;
    assign drop      = push && full && !pop;
    assign wr        = push && !drop;
    assign {evt_ext, evt_brk, evt_code} = evt_valid ? mem[rd_ptr] : 10'd0;

    // event storage; contents are only visible while count says they are valid
    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr] <= ev;
    end

    // FIFO pointers wrap naturally since depth is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr <= pop ? rd_ptr + AW'(1) : rd_ptr;
            count  <= count + {{AW{1'b0}}, wr} - {{AW{1'b0}}, pop};
        end
    end
endmodule

// File: tb/tb_ps2_scancode_ctrl.sv
// tb_ps2_scancode_ctrl: directed and random checks of ps2_scancode_ctrl against a prefix/queue reference model
module tb_ps2_scancode_ctrl;
    localparam int DEPTH = 4;
    localparam int TMO   = 65500;

    logic       clk = 1'b0, rst = 1'b1;
    logic       rx_valid = 1'b0, rx_err = 1'b0, evt_ready = 1'b0, ovf_clr = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       evt_valid, evt_ext, evt_brk, err_pulse, to_pulse, overflow;
    logic [7:0] evt_code;

    int n_assert = 0, n_fail = 0, pops = 0, tos = 0, errs = 0;

    logic [9:0] q[$];
    bit         m_ext, m_brk, m_ovf, m_err, m_to, f_v;
    logic [8:0] f_key;
    int         m_wait;

    ps2_scancode_ctrl dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .rx_err(rx_err),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code),
        .evt_ext(evt_ext), .evt_brk(evt_brk), .err_pulse(err_pulse),
        .to_pulse(to_pulse), .overflow(overflow), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; rx_err = 1'b0; evt_ready = 1'b0; ovf_clr = 1'b0;
        #2;
        chk("rst_evt_valid", evt_valid, 0);
        chk("rst_head", {evt_ext, evt_brk, evt_code}, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_err_pulse", err_pulse, 0);
        chk("rst_to_pulse", to_pulse, 0);
        q.delete();
        m_ext = 0; m_brk = 0; m_ovf = 0; m_err = 0; m_to = 0; f_v = 0; m_wait = 0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // one clock: drive inputs, compare outputs with the model, then advance the model
    task automatic cyc(input bit v, input logic [7:0] d, input bit e, input bit r, input bit c);
        logic [9:0] ev;
        bit push, pop, drop;
        rx_valid = v; rx_data = d; rx_err = e; evt_ready = r; ovf_clr = c;
        chk("evt_valid", evt_valid, q.size() != 0);
        if (q.size() != 0) chk("evt_head", {evt_ext, evt_brk, evt_code}, q[0]);
        chk("overflow", overflow, m_ovf);
        chk("err_pulse", err_pulse, m_err);
        chk("to_pulse", to_pulse, m_to);
        if (evt_valid && r) pops++;
        if (to_pulse) tos++;
        if (err_pulse) errs++;
        push = 0; m_err = 0; m_to = 0; ev = 0;
        if (v) begin
            if (e || d == 8'h00 || d == 8'hFF) begin
                m_err = 1; m_ext = 0; m_brk = 0;
            end else if (m_brk && (d == 8'hE0 || d == 8'hF0)) begin
                m_err = 1; m_ext = 0; m_brk = 0;
            end else if (d == 8'hE0) begin
                m_ext = 1; m_wait = 0;
            end else if (d == 8'hF0) begin
                m_brk = 1; m_wait = 0;
            end else begin
                ev = {m_ext, m_brk, d}; push = 1; m_ext = 0; m_brk = 0;
            end
        end else if (m_ext || m_brk) begin
            m_wait++;
            if (m_wait == TMO) begin m_to = 1; m_ext = 0; m_brk = 0; end
        end
`ifdef PS2_REPEAT_FILTER_EN
        if (push) begin
            if (!ev[8]) begin
                if (f_v && f_key == {ev[9], ev[7:0]}) push = 0;
                else begin f_v = 1; f_key = {ev[9], ev[7:0]}; end
            end else if (f_v && f_key == {ev[9], ev[7:0]}) f_v = 0;
        end
`endif
        pop  = r && q.size() != 0;
        drop = push && q.size() == DEPTH && !pop;
        if (pop) void'(q.pop_front());
        if (push && !drop) q.push_back(ev);
        m_ovf = c ? 1'b0 : (m_ovf || drop);
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [7:0] d, input bit r);
        cyc(1, d, 0, r, 0);
    endtask

    task automatic idle(input int n, input bit r);
        for (int i = 0; i < n; i++) cyc(0, 8'h00, 0, r, 0);
    endtask

    initial begin
        logic [7:0] exp_codes [4];
        logic [7:0] codes [4];
        exp_codes = '{8'h15, 8'h1D, 8'h24, 8'h2D};
        codes     = '{8'h1C, 8'h1D, 8'h15, 8'hE1};
        do_reset();

        send(8'h1C, 1);
        chk("make_valid", evt_valid, 1);
        chk("make_head", {evt_ext, evt_brk, evt_code}, 10'h01C);
        idle(2, 1);

        send(8'hE0, 0); send(8'hF0, 0); send(8'h74, 0);
        chk("ext_brk_head", {evt_ext, evt_brk, evt_code}, 10'h374);
        idle(1, 1);
        chk("ext_brk_single", evt_valid, 0);

        foreach (exp_codes[i]) send(exp_codes[i], 0);
        send(8'h2C, 0);
        chk("ovf_set", overflow, 1);
        cyc(0, 8'h00, 0, 0, 1);
        chk("ovf_clr", overflow, 0);
        pops = 0;
        for (int i = 0; i < 4; i++) begin
            chk("drain_code", evt_code, exp_codes[i]);
            idle(1, 1);
        end
        idle(2, 1);
        chk("drain_count", pops, 4);

        tos = 0;
        send(8'hE0, 1);
        idle(TMO + 5, 1);
        chk("timeout_once", tos, 1);
        send(8'h1C, 0);
        chk("after_to_head", {evt_ext, evt_brk, evt_code}, 10'h01C);
        idle(1, 1);

        errs = 0;
        send(8'hF0, 1);
        cyc(1, 8'h55, 1, 1, 0);
        idle(1, 1);
        chk("rx_err_pulse", errs, 1);
        chk("rx_err_no_evt", evt_valid, 0);
        send(8'h1C, 0);
        chk("after_err_head", {evt_ext, evt_brk, evt_code}, 10'h01C);
        idle(1, 1);

        send(8'h24, 0); send(8'hE0, 0);
        do_reset();

        pops = 0;
        send(8'h1C, 1); idle(1, 1);
        send(8'h1C, 1); idle(1, 1);
        send(8'h1C, 1); idle(1, 1);
        send(8'hF0, 1); send(8'h1C, 1);
        idle(3, 1);
`ifdef PS2_REPEAT_FILTER_EN
        chk("typematic_events", pops, 2);
`else
        chk("typematic_events", pops, 4);
`endif

        for (int i = 0; i < 3000; i++) begin
            int k;
            logic [7:0] d;
            k = $urandom_range(0, 15);
            d = k == 0 ? 8'hE0 : k == 1 ? 8'hF0 : k == 2 ? 8'h00 : k == 3 ? 8'hFF :
                k < 10 ? codes[$urandom_range(0, 3)] : 8'($urandom);
            cyc($urandom_range(0, 2) == 0, d, $urandom_range(0, 19) == 0,
                $urandom_range(0, 1) == 1, $urandom_range(0, 29) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
